// File: rtl/product_accumulator_if.sv
// Bundle of the product input stream, frame control and the frame-sum output
// stream of product_accumulator.
interface product_accumulator_if #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 72,
  parameter int CNT_WIDTH = 8
);
  logic                        prod_valid;
  logic                        prod_ready;
  logic signed [2*WIDTH-1:0]   prod;
  logic [CNT_WIDTH-1:0]        frame_len;
  logic                        clear;
  logic                        acc_valid;
  logic                        acc_ready;
  logic signed [ACC_WIDTH-1:0] acc_out;
  logic                        acc_ovf;
  logic                        busy;

  // Producer/consumer side: drives products, frame control and output ready.
  modport master (
    output prod_valid, prod, frame_len, clear, acc_ready,
    input  prod_ready, acc_valid, acc_out, acc_ovf, busy
  );

  // Accumulator side.
  modport slave (
    input  prod_valid, prod, frame_len, clear, acc_ready,
    output prod_ready, acc_valid, acc_out, acc_ovf, busy
  );
endinterface

// File: rtl/product_accumulator.sv
// Frame accumulator for signed multiplier products: sums frame_len products
// into a saturating ACC_WIDTH accumulator and holds the sum on a valid/ready
// output until the consumer takes it.
module product_accumulator #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 72,
  parameter int CNT_WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst,
  product_accumulator_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACC, EMIT} state_t;

  localparam logic signed [ACC_WIDTH-1:0] acc_max = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] acc_min = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  state_t                      state;
  logic signed [ACC_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0]        cnt;
  logic [CNT_WIDTH-1:0]        len_q;
  logic                        ovf;
  logic                        valid_q;
  logic                        busy_q;

  logic                        accept;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH:0]   sum_wide;
  logic signed [ACC_WIDTH-1:0] sum_sat;
  logic                        sum_clamped;
  logic [CNT_WIDTH-1:0]        cnt_inc;
  logic [CNT_WIDTH-1:0]        len_eff;

  // Ready is the only combinational output; clear and reset block acceptance.
  assign bus.prod_ready = !rst && !bus.clear && (state != EMIT);
  assign accept         = bus.prod_valid && bus.prod_ready;

  assign bus.acc_valid  = valid_q;
  assign bus.acc_out    = acc;
  assign bus.acc_ovf    = ovf;
  assign bus.busy       = busy_q;

  // A zero frame length behaves as a single-product frame.
  assign len_eff = (bus.frame_len == '0) ? CNT_WIDTH'(1) : bus.frame_len;
  assign cnt_inc = cnt + CNT_WIDTH'(1);

  // Widened sum with clamp to the signed accumulator range on overflow.
  always_comb begin
    prod_ext    = ACC_WIDTH'(bus.prod);
    sum_wide    = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(prod_ext);
    sum_sat     = sum_wide[ACC_WIDTH-1:0];
    sum_clamped = 1'b0;
    if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1]) begin
      sum_clamped = 1'b1;
      sum_sat     = sum_wide[ACC_WIDTH] ? acc_min : acc_max;
    end
  end

  // Frame control FSM with registered acc_valid/busy; clear overrides everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      len_q   <= '0;
      ovf     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (bus.clear) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            len_q  <= len_eff;
            acc    <= prod_ext;
            cnt    <= CNT_WIDTH'(1);
            ovf    <= 1'b0;
            busy_q <= 1'b1;
            if (len_eff == CNT_WIDTH'(1)) begin
              state   <= EMIT;
              valid_q <= 1'b1;
            end else begin
              state <= ACC;
            end
          end
        end
        ACC: begin
          if (accept) begin
            acc <= sum_sat;
            cnt <= cnt_inc;
            if (sum_clamped) begin
              ovf <= 1'b1;
            end
            if (cnt_inc == len_q) begin
              state   <= EMIT;
              valid_q <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (bus.acc_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
